// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register and write-back formatter.
// Aligns and sign/zero-extends load data (big-endian byte lanes), handles
// stall/flush bubbles and counts retired instructions.
// Optional HI/LO pipeline and architectural registers: define HILO_EN.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_mem,
  input  logic              stall_wb,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        mem_load_op,
  input  logic [1:0]        mem_byte_off,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef HILO_EN
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  output logic              wb_whilo,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
`endif
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_misalign,
  output logic [CNT_W-1:0]  wb_retired
);

  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [2:0] LD_LW  = 3'd5;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [DATA_W-1:0] fmt_data;
  logic              misaligned;

  logic              cap_we;
  logic [ADDR_W-1:0] cap_waddr;
  logic [DATA_W-1:0] cap_wdata;
  logic              cap_misalign;

  logic              do_bubble;
  logic              do_capture;

  // Flush beats everything; a MEM stall with WB free drains a bubble,
  // a stall on both holds, and anything else captures.
  always_comb begin
    do_bubble  = flush | (stall_mem & ~stall_wb);
    do_capture = ~flush & ~stall_mem;
  end

  // Load alignment/extension and capture-value formatting ahead of the register.
  always_comb begin
    sel_byte   = 8'h00;
    sel_half   = 16'h0000;
    misaligned = 1'b0;
    fmt_data   = mem_wdata;

    // Byte lane 0 is the most significant byte of the word.
    case (mem_byte_off)
      2'd0:    sel_byte = mem_rdata[31:24];
      2'd1:    sel_byte = mem_rdata[23:16];
      2'd2:    sel_byte = mem_rdata[15:8];
      default: sel_byte = mem_rdata[7:0];
    endcase
    sel_half = mem_byte_off[1] ? mem_rdata[15:0] : mem_rdata[31:16];

    case (mem_load_op)
      LD_LB:   fmt_data = {{(DATA_W-8){sel_byte[7]}}, sel_byte};
      LD_LBU:  fmt_data = {{(DATA_W-8){1'b0}}, sel_byte};
      LD_LH: begin
        misaligned = mem_byte_off[0];
        fmt_data   = {{(DATA_W-16){sel_half[15]}}, sel_half};
      end
      LD_LHU: begin
        misaligned = mem_byte_off[0];
        fmt_data   = {{(DATA_W-16){1'b0}}, sel_half};
      end
      LD_LW: begin
        misaligned = |mem_byte_off;
        fmt_data   = mem_rdata;
      end
      // 0 and the reserved codes 6/7 pass the ALU result through.
      default: fmt_data = mem_wdata;
    endcase

    cap_we       = mem_valid & mem_we & (|mem_waddr) & ~misaligned;
    cap_waddr    = mem_valid ? mem_waddr : '0;
    cap_wdata    = (mem_valid & ~misaligned) ? fmt_data : '0;
    cap_misalign = mem_valid & misaligned;
  end

  // WB slot register: bubble, capture, or hold when both stages stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_we       <= 1'b0;
      wb_waddr    <= '0;
      wb_wdata    <= '0;
      wb_misalign <= 1'b0;
    end else if (do_bubble) begin
      wb_we       <= 1'b0;
      wb_waddr    <= '0;
      wb_wdata    <= '0;
      wb_misalign <= 1'b0;
    end else if (do_capture) begin
      wb_we       <= cap_we;
      wb_waddr    <= cap_waddr;
      wb_wdata    <= cap_wdata;
      wb_misalign <= cap_misalign;
    end
  end

  // Retired counter: misaligned loads still retire; wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_retired <= '0;
    end else if (do_capture && mem_valid) begin
      wb_retired <= wb_retired + CNT_ONE;
    end
  end

`ifdef HILO_EN
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // HI/LO ride through the WB slot under the same stall/flush rules.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_whilo <= 1'b0;
      wb_hi    <= '0;
      wb_lo    <= '0;
    end else if (do_bubble) begin
      wb_whilo <= 1'b0;
      wb_hi    <= '0;
      wb_lo    <= '0;
    end else if (do_capture) begin
      wb_whilo <= mem_valid & mem_whilo;
      wb_hi    <= (mem_valid & mem_whilo) ? mem_hi : '0;
      wb_lo    <= (mem_valid & mem_whilo) ? mem_lo : '0;
    end
  end

  // Architectural HI/LO commit from the WB slot; re-committing a held slot
  // rewrites the same value, so no stall qualification is needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wb_whilo) begin
      hi_q <= wb_hi;
      lo_q <= wb_lo;
    end
  end

  // Forward the in-flight WB values so readers see them in the WB cycle.
  always_comb begin
    hi_o = wb_whilo ? wb_hi : hi_q;
    lo_o = wb_whilo ? wb_lo : lo_q;
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed spec scenarios plus randomized traffic against a
// behavioural model of the MEM->WB stage. Define HILO_EN to cover HI/LO.
`timescale 1ns/1ps
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        stall_mem, stall_wb, flush;
  logic        mem_valid, mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_load_op;
  logic [1:0]  mem_byte_off;
  logic [31:0] mem_rdata;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_misalign;
  logic [31:0] wb_retired;
`ifdef HILO_EN
  logic        mem_whilo;
  logic [31:0] mem_hi, mem_lo;
  logic        wb_whilo;
  logic [31:0] hi_o, lo_o;
`endif

  int checks;
  int failures;

  // model state
  bit          e_we, e_mis;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;
  logic [31:0] e_ret;
`ifdef HILO_EN
  bit          e_whilo;
  logic [31:0] e_hi_wb, e_lo_wb, e_hi, e_lo;
`endif

  mem_wb_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_mem    (stall_mem),
    .stall_wb     (stall_wb),
    .flush        (flush),
    .mem_valid    (mem_valid),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_load_op  (mem_load_op),
    .mem_byte_off (mem_byte_off),
    .mem_rdata    (mem_rdata),
`ifdef HILO_EN
    .mem_whilo    (mem_whilo),
    .mem_hi       (mem_hi),
    .mem_lo       (mem_lo),
    .wb_whilo     (wb_whilo),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
`endif
    .wb_we        (wb_we),
    .wb_waddr     (wb_waddr),
    .wb_wdata     (wb_wdata),
    .wb_misalign  (wb_misalign),
    .wb_retired   (wb_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Load result from the ISA rules: lane n of a big-endian word is bits
  // [31-8n -: 8]; halfword k is bits [31-16k -: 16].
  function automatic void ref_format(input int op, input int off, input logic [31:0] rdata,
                                     input logic [31:0] alu, output logic [31:0] v, output bit mis);
    int unsigned b, h;
    b   = (rdata >> (8 * (3 - off))) & 32'hFF;
    h   = (rdata >> (16 * (1 - off / 2))) & 32'hFFFF;
    mis = 0;
    v   = alu;
    case (op)
      1: v = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      2: v = b;
      3: begin mis = (off % 2) != 0; v = (h >= 32768) ? (h | 32'hFFFF_0000) : h; end
      4: begin mis = (off % 2) != 0; v = h; end
      5: begin mis = off != 0; v = rdata; end
      default: v = alu;
    endcase
  endfunction

  task automatic model_reset();
    e_we = 0; e_mis = 0; e_waddr = '0; e_wdata = '0; e_ret = '0;
`ifdef HILO_EN
    e_whilo = 0; e_hi_wb = '0; e_lo_wb = '0; e_hi = '0; e_lo = '0;
`endif
  endtask

  task automatic model_edge();
    logic [31:0] v;
    bit mis;
`ifdef HILO_EN
    if (e_whilo) begin e_hi = e_hi_wb; e_lo = e_lo_wb; end
`endif
    if (flush || (stall_mem && !stall_wb)) begin
      e_we = 0; e_mis = 0; e_waddr = '0; e_wdata = '0;
`ifdef HILO_EN
      e_whilo = 0; e_hi_wb = '0; e_lo_wb = '0;
`endif
    end else if (!stall_mem) begin
      ref_format(int'(mem_load_op), int'(mem_byte_off), mem_rdata, mem_wdata, v, mis);
      e_we    = mem_valid && mem_we && (mem_waddr != 0) && !mis;
      e_mis   = mem_valid && mis;
      e_waddr = mem_valid ? mem_waddr : 5'd0;
      e_wdata = (mem_valid && !mis) ? v : 32'd0;
      if (mem_valid) e_ret = e_ret + 1;
`ifdef HILO_EN
      e_whilo = mem_valid && mem_whilo;
      e_hi_wb = e_whilo ? mem_hi : '0;
      e_lo_wb = e_whilo ? mem_lo : '0;
`endif
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".we"},       {31'd0, wb_we},       {31'd0, e_we});
    check_eq({tag, ".waddr"},    {27'd0, wb_waddr},    {27'd0, e_waddr});
    check_eq({tag, ".wdata"},    wb_wdata,             e_wdata);
    check_eq({tag, ".misalign"}, {31'd0, wb_misalign}, {31'd0, e_mis});
    check_eq({tag, ".retired"},  wb_retired,           e_ret);
`ifdef HILO_EN
    check_eq({tag, ".whilo"}, {31'd0, wb_whilo}, {31'd0, e_whilo});
    check_eq({tag, ".hi"}, hi_o, e_whilo ? e_hi_wb : e_hi);
    check_eq({tag, ".lo"}, lo_o, e_whilo ? e_lo_wb : e_lo);
`endif
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    stall_mem = 0; stall_wb = 0; flush = 0;
    mem_valid = 0; mem_we = 0; mem_waddr = '0; mem_wdata = '0;
    mem_load_op = '0; mem_byte_off = '0; mem_rdata = '0;
`ifdef HILO_EN
    mem_whilo = 0; mem_hi = '0; mem_lo = '0;
`endif
  endtask

  task automatic instr(input logic [4:0] wa, input logic [31:0] wd, input logic [2:0] op,
                       input logic [1:0] off, input logic [31:0] rd);
    mem_valid = 1; mem_we = 1; mem_waddr = wa; mem_wdata = wd;
    mem_load_op = op; mem_byte_off = off; mem_rdata = rd;
  endtask

  typedef struct { logic [2:0] op; logic [1:0] off; logic [31:0] res; } load_vec_t;
  load_vec_t lv[5];

  initial begin
    checks = 0; failures = 0;
    idle();
    model_reset();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check_eq("reset.retired0", wb_retired, 32'd0);
    @(negedge clk);
    rst = 1;

    // ALU writeback
    @(posedge clk); #1;
    instr(5'd5, 32'h1234_5678, 3'd0, 2'd0, 32'h0);
    cycle("alu");
    check_eq("alu.wdata_const", wb_wdata, 32'h1234_5678);
    check_eq("alu.retired_const", wb_retired, 32'd1);

    // load formatting on 0x80FF_7F01
    lv[0] = '{3'd1, 2'd0, 32'hFFFF_FF80};
    lv[1] = '{3'd2, 2'd0, 32'h0000_0080};
    lv[2] = '{3'd1, 2'd2, 32'h0000_007F};
    lv[3] = '{3'd3, 2'd2, 32'h0000_7F01};
    lv[4] = '{3'd4, 2'd0, 32'h0000_80FF};
    for (int i = 0; i < 5; i++) begin
      instr(5'd7, 32'hDEAD_BEEF, lv[i].op, lv[i].off, 32'h80FF_7F01);
      cycle("load");
      check_eq("load.const", wb_wdata, lv[i].res);
    end

    // misaligned LW
    instr(5'd8, 32'h0, 3'd5, 2'd2, 32'h1111_2222);
    cycle("mis");
    check_eq("mis.we_const", {31'd0, wb_we}, 32'd0);
    check_eq("mis.flag_const", {31'd0, wb_misalign}, 32'd1);
    idle();
    cycle("mis_after");
    check_eq("mis_after.flag_const", {31'd0, wb_misalign}, 32'd0);

    // stall sequence
    instr(5'd3, 32'hAAAA_0001, 3'd0, 2'd0, 32'h0);
    cycle("stallA");
    instr(5'd4, 32'hBBBB_0002, 3'd0, 2'd0, 32'h0);
    stall_mem = 1; stall_wb = 1;
    cycle("hold1");
    cycle("hold2");
    check_eq("hold.wdata_const", wb_wdata, 32'hAAAA_0001);
    stall_wb = 0;
    cycle("drain");
    check_eq("drain.we_const", {31'd0, wb_we}, 32'd0);
    stall_mem = 0;
    cycle("stallB");
    check_eq("stallB.wdata_const", wb_wdata, 32'hBBBB_0002);

    // write to $0, flush on valid write
    instr(5'd0, 32'h5555_5555, 3'd0, 2'd0, 32'h0);
    cycle("r0");
    instr(5'd9, 32'h9999_9999, 3'd0, 2'd0, 32'h0);
    flush = 1;
    cycle("flush");
    flush = 0;

`ifdef HILO_EN
    idle();
    mem_valid = 1; mem_whilo = 1; mem_hi = 32'hA; mem_lo = 32'hB;
    cycle("hilo_wb");
    check_eq("hilo_wb.hi_const", hi_o, 32'hA);
    idle();
    cycle("hilo_after");
    cycle("hilo_after2");
    check_eq("hilo_after.lo_const", lo_o, 32'hB);
`endif

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      stall_mem    = ($urandom_range(0, 3) == 0);
      stall_wb     = ($urandom_range(0, 2) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      mem_valid    = ($urandom_range(0, 4) != 0);
      mem_we       = ($urandom_range(0, 5) != 0);
      mem_waddr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      mem_wdata    = $urandom;
      mem_load_op  = 3'($urandom);
      mem_byte_off = 2'($urandom);
      mem_rdata    = $urandom;
`ifdef HILO_EN
      mem_whilo    = ($urandom_range(0, 3) == 0);
      mem_hi       = $urandom;
      mem_lo       = $urandom;
`endif
      cycle("rand");
    end

    // asynchronous reset between edges while a write is in WB, with stalls asserted
    idle();
    instr(5'd12, 32'hCAFE_F00D, 3'd0, 2'd0, 32'h0);
    cycle("pre_rst");
    check_eq("pre_rst.we_const", {31'd0, wb_we}, 32'd1);
    stall_mem = 1; stall_wb = 1; flush = 1;
    #2;
    rst = 0;
    model_reset();
    #1;
    check_all("async_rst");
    check_eq("async_rst.wdata_const", wb_wdata, 32'd0);
    @(negedge clk);
    rst = 1;
    idle();
    instr(5'd2, 32'h0BAD_CAFE, 3'd0, 2'd0, 32'h0);
    cycle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
